pce_cd_phase_sequencer: RTL
===========================

# pce_cd_phase_sequencer

Synthesizable SCSI target-side phase sequencer for the PC Engine CD-ROM interface. It owns bus phase, the CDC_STAT status byte and the REQ/ACK byte handshake. It collects a command from the host, hands it to the drive backend, streams the backend's data bytes, then returns status and message before releasing the bus. It sits between the CPU-facing CD register file and the drive/sector backend.

## Interface
- `CMD_MAX`, 12, size of the command buffer in bytes; must be ≥ 12.
- `LEN_W`, 16, width of the data-in byte counter.
- `MSG_BYTE`, 8'h00, byte presented in MESSAGE_IN (COMMAND COMPLETE).

Ports:
- `clk` in 1: sole clock; everything is rising-edge.
- `reset` in 1: synchronous, active-high.
- `sel_i` in 1: host select pulse.
- `ack_i` in 1: host ACK pulse.
- `host_data_i` in 8: command byte from the host, sampled with ACK.
- `cd_status_o` out 8: CDC_STAT register. Bit 7 BSY, 6 REQ, 5 MSG, 4 C/D, 3 I/O; bits 2:0 are always 0.
- `phase_o` out 8: BUS_FREE 8'h00, COMMAND 8'h01, DATA_IN 8'h02, STATUS 8'h08, MESSAGE_IN 8'h10.
- `bus_data_o` out 8: byte offered to the host.
- `cmd_valid_o` out 1: one-cycle pulse when the command is complete.
- `cmd_bytes_o` out CMD_MAX*8: command bytes; byte 0 is at [7:0].
- `cmd_len_o` out 4: number of command bytes.
- `resp_valid_i` in 1: backend response strobe.
- `resp_len_i` in LEN_W: number of data-in bytes.
- `resp_status_i` in 8: SCSI status byte.
- `din_valid_i` in 1, `din_i` in 8, `din_ready_o` out 1: backend data byte stream; a byte transfers when valid and ready are both high.

## Operation
States: BUS_FREE, COMMAND, WAIT_RESP, DATA_IN, STATUS, MSG_IN.

Control bits per state (REQ is added separately):
- BUS_FREE: status 8'h00.
- COMMAND: BSY and C/D set.
- WAIT_RESP: BSY and C/D set, REQ 0; `phase_o` stays COMMAND.
- DATA_IN: BSY and I/O set.
- STATUS: BSY, C/D and I/O set.
- MSG_IN: BSY, MSG, C/D and I/O set.

Transitions:
- **BUS_FREE → COMMAND** on `sel_i`.
- **COMMAND:** each ACK while REQ=1 captures `host_data_i` at index `cnt`.
  - Required length comes from byte 0 bits [7:5]: group 0 gives 6, groups 1 and 2 give 10, group 5 gives 12, anything else gives 6.
  - After the last byte: pulse `cmd_valid_o`, set `cmd_len_o`, go to WAIT_RESP.
- **WAIT_RESP:** on `resp_valid_i`, latch status and length.
  - Length 0: go to STATUS.
  - Otherwise: go to DATA_IN with the counter loaded from `resp_len_i`.
- **DATA_IN:**
  - `din_ready_o` = 1 while no byte is held.
  - When a byte is accepted it is held on `bus_data_o` and REQ is raised.
  - ACK releases the byte and decrements the counter. When the counter reaches 0, go to STATUS.
- **STATUS:** present the latched status; ACK moves to MSG_IN.
- **MSG_IN:** present `MSG_BYTE`; ACK moves to BUS_FREE.

Ignored inputs:
- `ack_i` while REQ=0.
- `sel_i` outside BUS_FREE.
- `resp_valid_i` outside WAIT_RESP.
- `din_valid_i` outside DATA_IN, or while a byte is held.

## Timing
- Reset values:
  - `cd_status_o` = 8'h00, `phase_o` = 8'h00, `bus_data_o` = 8'h00.
  - `cmd_valid_o` = 0, `din_ready_o` = 0, `cmd_len_o` = 0, `cmd_bytes_o` = all zeros.
  - Byte counters cleared, no byte held.
- Reset at any point, including mid-transfer, returns to BUS_FREE on the next edge. Reset wins over any simultaneous input.
- `sel_i` in cycle N: in cycle N+1 the phase is COMMAND and REQ=1 (status 8'hD0).
- ACK in cycle N: REQ=0 in N+1, and any phase change is visible in N+1.
  - The next REQ rises no earlier than N+2, giving a mandatory one-cycle REQ-low gap.
  - In COMMAND, STATUS and MSG_IN, REQ rises exactly at N+2.
- Last command ACK in cycle N: `cmd_valid_o` = 1 in N+1 only; state WAIT_RESP in N+1.
- `resp_valid_i` in cycle N: in N+1, either DATA_IN with REQ=0 and `din_ready_o`=1, or STATUS with REQ=0. STATUS REQ rises at N+2.
- Byte accepted in cycle M: in M+1, `bus_data_o` = byte, REQ=1, `din_ready_o`=0.
  - After that byte's ACK (at N), `din_ready_o`=1 in N+1 if bytes remain.
- `bus_data_o` holds stable for the whole time REQ=1.
- Counter arithmetic is LEN_W-bit unsigned. A `resp_len_i` of all ones must transfer exactly that many bytes, with no wrap-around.

## Test plan
- **Reset:** drive `reset` for 2 cycles → status 00, phase 00, `din_ready_o` 0.
- **Group-0 command, no data:** sel, then 6 bytes `08 00 00 10 01 00` with ACKs → status D0 during COMMAND; `cmd_valid_o` pulses once with `cmd_len_o`=6 and bytes matching. Then `resp_len`=0, status 8'h02 → D8 with `bus_data_o`=02; ACK → F8 with `bus_data_o`=00; ACK → 00.
- **Group-1 command and data-in:** 10-byte command `28 …`, `resp_len`=3, data `A1 A2 A3` → each byte presented with status C8. Exactly 3 ACKs, then STATUS; REQ is low for one cycle after every ACK.
- **Backpressure:** `din_valid_i` delayed 5 cycles in DATA_IN → status stays 88 with REQ=0 until the byte arrives. ACKs while REQ=0, and `sel_i` mid-command, have no effect.
- **Mid-transfer reset:** assert `reset` after the 2nd of 3 data bytes → next cycle status 00, phase BUS_FREE. A new sel then starts a clean command, with byte 0 stored at index 0.
- **Counter boundary:** `resp_len`=16'hFFFF → exactly 65535 bytes are accepted before STATUS.

Source files
------------

// File: rtl/pce_cd_phase_sequencer.sv
// PC Engine CD-ROM target-side SCSI phase sequencer: collects a command, streams
// backend data bytes, then returns status and message over a REQ/ACK byte handshake.
//
// state     | meaning
// BUS_FREE  | idle, waiting for host select
// COMMAND   | collecting command bytes from the host
// WAIT_RESP | command handed off, waiting for the backend response
// DATA_IN   | streaming backend bytes to the host
// STATUS    | presenting the latched SCSI status byte
// MSG_IN    | presenting the COMMAND COMPLETE message byte
module pce_cd_phase_sequencer #(
    parameter int unsigned CMD_MAX  = 12,
    parameter int unsigned LEN_W    = 16,
    parameter logic [7:0]  MSG_BYTE = 8'h00
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sel_i,
    input  logic                 ack_i,
    input  logic [7:0]           host_data_i,
    output logic [7:0]           cd_status_o,
    output logic [7:0]           phase_o,
    output logic [7:0]           bus_data_o,
    output logic                 cmd_valid_o,
    output logic [CMD_MAX*8-1:0] cmd_bytes_o,
    output logic [3:0]           cmd_len_o,
    input  logic                 resp_valid_i,
    input  logic [LEN_W-1:0]     resp_len_i,
    input  logic [7:0]           resp_status_i,
    input  logic                 din_valid_i,
    input  logic [7:0]           din_i,
    output logic                 din_ready_o
);

    typedef enum logic [2:0] {
        S_BUS_FREE,
        S_COMMAND,
        S_WAIT_RESP,
        S_DATA_IN,
        S_STATUS,
        S_MSG_IN
    } state_t;

    localparam logic [LEN_W-1:0] LEN_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    state_t               state_q, state_d;
    logic                 req_q, req_d;
    logic [3:0]           cnt_q, cnt_d;
    logic [3:0]           need_q, need_d;
    logic [LEN_W-1:0]     len_q, len_d;
    logic [7:0]           stat_q, stat_d;
    logic [7:0]           data_q, data_d;
    logic [CMD_MAX*8-1:0] cmd_bytes_q, cmd_bytes_d;
    logic [3:0]           cmd_len_q, cmd_len_d;
    logic                 cmd_valid_q, cmd_valid_d;

    logic [3:0] need_cur;
    logic       cmd_last;
    logic [7:0] ctl;

    function automatic logic [3:0] cdb_len(input logic [2:0] grp);
        case (grp)
            3'd0:       cdb_len = 4'd6;
            3'd1, 3'd2: cdb_len = 4'd10;
            3'd5:       cdb_len = 4'd12;
            default:    cdb_len = 4'd6;
        endcase
    endfunction

    // The length is only known once byte 0 arrives, so decode it straight off the bus then.
    assign need_cur = (cnt_q == 4'd0) ? cdb_len(host_data_i[7:5]) : need_q;
    assign cmd_last = (cnt_q + 4'd1) == need_cur;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_BUS_FREE;
            req_q       <= 1'b0;
            cnt_q       <= '0;
            need_q      <= '0;
            len_q       <= '0;
            stat_q      <= '0;
            data_q      <= '0;
            cmd_bytes_q <= '0;
            cmd_len_q   <= '0;
            cmd_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            req_q       <= req_d;
            cnt_q       <= cnt_d;
            need_q      <= need_d;
            len_q       <= len_d;
            stat_q      <= stat_d;
            data_q      <= data_d;
            cmd_bytes_q <= cmd_bytes_d;
            cmd_len_q   <= cmd_len_d;
            cmd_valid_q <= cmd_valid_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        cnt_d       = cnt_q;
        need_d      = need_q;
        len_d       = len_q;
        stat_d      = stat_q;
        data_d      = data_q;
        cmd_bytes_d = cmd_bytes_q;
        cmd_len_d   = cmd_len_q;
        cmd_valid_d = 1'b0;

        case (state_q)
            S_BUS_FREE: begin
                if (sel_i) begin
                    state_d     = S_COMMAND;
                    req_d       = 1'b1;
                    cnt_d       = '0;
                    cmd_bytes_d = '0;
                end
            end
            S_COMMAND: begin
                // REQ low for exactly one cycle after each ACK, then re-raised.
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (ack_i) begin
                    req_d = 1'b0;
                    cmd_bytes_d[cnt_q*8 +: 8] = host_data_i;
                    if (cnt_q == 4'd0) need_d = need_cur;
                    if (cmd_last) begin
                        state_d     = S_WAIT_RESP;
                        cmd_valid_d = 1'b1;
                        cmd_len_d   = need_cur;
                        cnt_d       = '0;
                    end else begin
                        cnt_d = cnt_q + 4'd1;
                    end
                end
            end
            S_WAIT_RESP: begin
                if (resp_valid_i) begin
                    stat_d  = resp_status_i;
                    len_d   = resp_len_i;
                    state_d = (resp_len_i == '0) ? S_STATUS : S_DATA_IN;
                end
            end
            S_DATA_IN: begin
                // In this phase REQ doubles as the "byte held" flag.
                if (!req_q) begin
                    if (din_valid_i) begin
                        data_d = din_i;
                        req_d  = 1'b1;
                    end
                end else if (ack_i) begin
                    req_d = 1'b0;
                    len_d = len_q - LEN_ONE;
                    if (len_q == LEN_ONE) state_d = S_STATUS;
                end
            end
            S_STATUS: begin
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (ack_i) begin
                    req_d   = 1'b0;
                    state_d = S_MSG_IN;
                end
            end
            S_MSG_IN: begin
                if (!req_q) begin
                    req_d = 1'b1;
                end else if (ack_i) begin
                    req_d   = 1'b0;
                    state_d = S_BUS_FREE;
                end
            end
            default: begin
                state_d = S_BUS_FREE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_comb begin
        ctl        = 8'h00;
        phase_o    = 8'h00;
        bus_data_o = data_q;
        case (state_q)
            S_COMMAND:   begin ctl = 8'h90; phase_o = 8'h01; end
            S_WAIT_RESP: begin ctl = 8'h90; phase_o = 8'h01; end
            S_DATA_IN:   begin ctl = 8'h88; phase_o = 8'h02; end
            S_STATUS:    begin ctl = 8'h98; phase_o = 8'h08; bus_data_o = stat_q; end
            S_MSG_IN:    begin ctl = 8'hB8; phase_o = 8'h10; bus_data_o = MSG_BYTE; end
            default:     begin ctl = 8'h00; phase_o = 8'h00; end
        endcase
    end

    assign cd_status_o = ctl | {1'b0, req_q, 6'b000000};
    assign din_ready_o = (state_q == S_DATA_IN) && !req_q;
    assign cmd_valid_o = cmd_valid_q;
    assign cmd_bytes_o = cmd_bytes_q;
    assign cmd_len_o   = cmd_len_q;

endmodule
